// File: rtl/mac_stop_ctrl_pkg.sv
// Shared definitions for the matrix MAC sequencer: FSM encoding and index-width helper.
package mac_stop_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int idx_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// PIPE_LAT-deep valid+payload shift register that carries loop indices alongside
// operand reads so each product leaves with its own index tuple.
module mac_tag_pipe #(
    parameter int PIPE_LAT = 2,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag,
    output logic             empty
);

    logic [PIPE_LAT-1:0] vld_p;
    logic [TAG_W-1:0]    tag_p [PIPE_LAT];

    // Stage boundary: payload only moves with a valid, so the final stage holds its last tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
            for (int s = 0; s < PIPE_LAT; s++) tag_p[s] <= '0;
        end else begin
            vld_p[0] <= in_vld;
            if (in_vld) tag_p[0] <= in_tag;
            for (int s = 1; s < PIPE_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
                if (vld_p[s-1]) tag_p[s] <= tag_p[s-1];
            end
        end
    end

    assign out_vld = vld_p[PIPE_LAT-1];
    assign out_tag = tag_p[PIPE_LAT-1];

    // High when nothing will remain after the next edge: the final stage is leaving now.
    always_comb begin
        empty = !in_vld;
        for (int s = 0; s < PIPE_LAT - 1; s++) begin
            if (vld_p[s]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/mac_stop_ctrl.sv
// Sequencer for C = A*B: walks (i, j, k) with k fastest, issues operand reads and
// delivers an index-tagged product strobe; supports abort with a clean drain.
module mac_stop_ctrl
    import mac_stop_ctrl_pkg::*;
#(
    parameter int M        = 4,
    parameter int K        = 4,
    parameter int N        = 4,
    parameter int PIPE_LAT = 2,
    localparam int AW_M    = idx_w(M),
    localparam int AW_K    = idx_w(K),
    localparam int AW_N    = idx_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    output logic            rd_en,
    output logic [AW_M-1:0] addr_a_row,
    output logic [AW_K-1:0] addr_a_col,
    output logic [AW_K-1:0] addr_b_row,
    output logic [AW_N-1:0] addr_b_col,
    output logic            mult_done,
    output logic [AW_M-1:0] tag_row,
    output logic [AW_K-1:0] tag_k,
    output logic [AW_N-1:0] tag_col,
    output logic            acc_clr,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam int TAG_W = AW_M + AW_K + AW_N;

    state_t          state, state_nxt;
    logic [AW_M-1:0] i;
    logic [AW_K-1:0] k;
    logic [AW_N-1:0] j;
    logic            at_last;
    logic            pipe_empty;
    logic [TAG_W-1:0] tag_out;

    assign at_last = (i == AW_M'(M - 1)) && (j == AW_N'(N - 1)) && (k == AW_K'(K - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        acc_clr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    rd_en = 1'b1;
                    if (at_last) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                acc_clr   = aborted;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters always hold the next tuple to issue; wraps compare against bound-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i       <= '0;
            j       <= '0;
            k       <= '0;
            aborted <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                i       <= '0;
                j       <= '0;
                k       <= '0;
                aborted <= 1'b0;
            end else if (rd_en) begin
                if (k == AW_K'(K - 1)) begin
                    k <= '0;
                    if (j == AW_N'(N - 1)) begin
                        j <= '0;
                        if (i == AW_M'(M - 1)) i <= '0;
                        else                   i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end else begin
                    k <= k + 1'b1;
                end
            end
            if (state == ST_RUN && stop) aborted <= 1'b1;
        end
    end

    assign addr_a_row = i;
    assign addr_a_col = k;
    assign addr_b_row = k;
    assign addr_b_col = j;

    mac_tag_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .TAG_W    (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_en),
        .in_tag  ({i, k, j}),
        .out_vld (mult_done),
        .out_tag (tag_out),
        .empty   (pipe_empty)
    );

    assign {tag_row, tag_k, tag_col} = tag_out;

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Bench for mac_stop_ctrl: a 2x2x2/PIPE_LAT=2 and a 3x3x2/PIPE_LAT=1 instance share
// stimulus; a per-cycle reference model plus per-pass timing checks judge both.
module tb_mac_stop_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop;

    logic       rd_en0, md0, clr0, busy0, done0, ab0;
    logic [0:0] ar0, ac0, br0, bc0, tr0, tk0, tc0;
    logic       rd_en1, md1, clr1, busy1, done1, ab1;
    logic [1:0] ar1, ac1, br1, tr1, tk1;
    logic [0:0] bc1, tc1;

    mac_stop_ctrl #(.M(2), .K(2), .N(2), .PIPE_LAT(2)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .rd_en(rd_en0), .addr_a_row(ar0), .addr_a_col(ac0), .addr_b_row(br0), .addr_b_col(bc0),
        .mult_done(md0), .tag_row(tr0), .tag_k(tk0), .tag_col(tc0),
        .acc_clr(clr0), .busy(busy0), .done(done0), .aborted(ab0)
    );

    mac_stop_ctrl #(.M(3), .K(3), .N(2), .PIPE_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .rd_en(rd_en1), .addr_a_row(ar1), .addr_a_col(ac1), .addr_b_row(br1), .addr_b_col(bc1),
        .mult_done(md1), .tag_row(tr1), .tag_k(tk1), .tag_col(tc1),
        .acc_clr(clr1), .busy(busy1), .done(done1), .aborted(ab1)
    );

    int o_rd[2], o_ar[2], o_ac[2], o_br[2], o_bc[2], o_md[2], o_tr[2], o_tk[2], o_tc[2];
    int o_clr[2], o_busy[2], o_done[2], o_ab[2];

    always_comb begin
        o_rd[0] = int'(rd_en0); o_ar[0] = int'(ar0); o_ac[0] = int'(ac0); o_br[0] = int'(br0);
        o_bc[0] = int'(bc0);    o_md[0] = int'(md0); o_tr[0] = int'(tr0); o_tk[0] = int'(tk0);
        o_tc[0] = int'(tc0);    o_clr[0] = int'(clr0); o_busy[0] = int'(busy0);
        o_done[0] = int'(done0); o_ab[0] = int'(ab0);
        o_rd[1] = int'(rd_en1); o_ar[1] = int'(ar1); o_ac[1] = int'(ac1); o_br[1] = int'(br1);
        o_bc[1] = int'(bc1);    o_md[1] = int'(md1); o_tr[1] = int'(tr1); o_tk[1] = int'(tk1);
        o_tc[1] = int'(tc1);    o_clr[1] = int'(clr1); o_busy[1] = int'(busy1);
        o_done[1] = int'(done1); o_ab[1] = int'(ab1);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model configuration and state
    int pM[2] = '{2, 3};
    int pK[2] = '{2, 3};
    int pN[2] = '{2, 2};
    int pL[2] = '{2, 1};

    localparam int MD_IDLE = 0, MD_RUN = 1, MD_DRAIN = 2, MD_DONE = 3;
    int m_mode[2], m_cnt[2], m_ab[2], m_tr[2], m_tk[2], m_tc[2];
    int due_v[2][8], due_i[2][8], due_j[2][8], due_k[2][8];

    int cyc  = 0;
    int cyc0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int st_nrd[2], st_frd[2], st_lrd[2], st_nmd[2], st_fmd[2], st_lmd[2];
    int st_done[2], st_clr[2], st_ab[2], st_tr[2], st_tk[2], st_tc[2];

    task automatic clear_stats();
        for (int u = 0; u < 2; u++) begin
            st_nrd[u] = 0; st_frd[u] = -1; st_lrd[u] = -1;
            st_nmd[u] = 0; st_fmd[u] = -1; st_lmd[u] = -1;
            st_done[u] = -1; st_clr[u] = -1;
        end
    endtask

    task automatic model_reset(input int u);
        m_mode[u] = MD_IDLE; m_cnt[u] = 0; m_ab[u] = 0;
        m_tr[u] = 0; m_tk[u] = 0; m_tc[u] = 0;
        for (int s = 0; s < 8; s++) due_v[u][s] = 0;
    endtask

    task automatic model_step(input int u);
        int now, slot, rel, mnk, n, ci, cj, ck, e_rd, e_md, pend, s2;
        string p;
        now  = cyc;
        slot = now % 8;
        rel  = cyc - cyc0;
        p    = (u == 0) ? "u0" : "u1";

        if (o_rd[u] != 0) begin st_nrd[u]++; if (st_frd[u] < 0) st_frd[u] = rel; st_lrd[u] = rel; end
        if (o_md[u] != 0) begin st_nmd[u]++; if (st_fmd[u] < 0) st_fmd[u] = rel; st_lmd[u] = rel; end
        if (o_done[u] != 0 && st_done[u] < 0) st_done[u] = rel;
        if (o_clr[u] != 0 && st_clr[u] < 0) st_clr[u] = rel;
        st_ab[u] = o_ab[u]; st_tr[u] = o_tr[u]; st_tk[u] = o_tk[u]; st_tc[u] = o_tc[u];

        if (reset) begin
            model_reset(u);
            check_eq({p, "_rst_rd"},   o_rd[u],   0);
            check_eq({p, "_rst_md"},   o_md[u],   0);
            check_eq({p, "_rst_busy"}, o_busy[u], 0);
            check_eq({p, "_rst_done"}, o_done[u], 0);
            check_eq({p, "_rst_clr"},  o_clr[u],  0);
            check_eq({p, "_rst_ab"},   o_ab[u],   0);
            check_eq({p, "_rst_addr"}, o_ar[u] + o_ac[u] + o_br[u] + o_bc[u], 0);
            check_eq({p, "_rst_tag"},  o_tr[u] + o_tk[u] + o_tc[u], 0);
            return;
        end

        mnk = pM[u] * pN[u] * pK[u];
        n   = m_cnt[u] % mnk;
        ci  = n / (pN[u] * pK[u]);
        cj  = (n / pK[u]) % pN[u];
        ck  = n % pK[u];

        e_rd = (m_mode[u] == MD_RUN && !stop) ? 1 : 0;
        e_md = due_v[u][slot];
        if (e_md != 0) begin
            m_tr[u] = due_i[u][slot]; m_tk[u] = due_k[u][slot]; m_tc[u] = due_j[u][slot];
        end
        due_v[u][slot] = 0;

        check_eq({p, "_rd_en"},   o_rd[u],   e_rd);
        check_eq({p, "_busy"},    o_busy[u], (m_mode[u] == MD_RUN || m_mode[u] == MD_DRAIN) ? 1 : 0);
        check_eq({p, "_done"},    o_done[u], (m_mode[u] == MD_DONE) ? 1 : 0);
        check_eq({p, "_acc_clr"}, o_clr[u],  (m_mode[u] == MD_DONE) ? m_ab[u] : 0);
        check_eq({p, "_aborted"}, o_ab[u],   m_ab[u]);
        check_eq({p, "_mdone"},   o_md[u],   e_md);
        check_eq({p, "_tag_row"}, o_tr[u],   m_tr[u]);
        check_eq({p, "_tag_k"},   o_tk[u],   m_tk[u]);
        check_eq({p, "_tag_col"}, o_tc[u],   m_tc[u]);
        if (e_rd != 0) begin
            check_eq({p, "_addr_a_row"}, o_ar[u], ci);
            check_eq({p, "_addr_a_col"}, o_ac[u], ck);
            check_eq({p, "_addr_b_row"}, o_br[u], ck);
            check_eq({p, "_addr_b_col"}, o_bc[u], cj);
        end

        case (m_mode[u])
            MD_IDLE: begin
                if (start) begin m_mode[u] = MD_RUN; m_cnt[u] = 0; m_ab[u] = 0; end
            end
            MD_RUN: begin
                if (stop) begin
                    m_mode[u] = MD_DRAIN; m_ab[u] = 1;
                end else begin
                    s2 = (now + pL[u]) % 8;
                    due_v[u][s2] = 1; due_i[u][s2] = ci; due_j[u][s2] = cj; due_k[u][s2] = ck;
                    m_cnt[u]++;
                    if (m_cnt[u] == mnk) m_mode[u] = MD_DRAIN;
                end
            end
            MD_DRAIN: begin
                pend = 0;
                for (int s = 0; s < 8; s++) if (due_v[u][s] != 0) pend = 1;
                if (pend == 0) m_mode[u] = MD_DONE;
            end
            default: m_mode[u] = MD_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) model_step(u);
    end

    // One directed pass: bit r of each mask drives that input during relative cycle r.
    task automatic scenario(input int len, input logic [63:0] st_m, input logic [63:0] sp_m,
                            input logic [63:0] rs_m);
        for (int r = 0; r < len; r++) begin
            @(posedge clk);
            #1;
            if (r == 0) begin cyc0 = cyc; clear_stats(); end
            start = st_m[r];
            stop  = sp_m[r];
            reset = rs_m[r];
        end
        @(negedge clk);
        #1;
        start = 1'b0; stop = 1'b0; reset = 1'b0;
    endtask

    task automatic chk_pass(input string nm, input int u, input int nrd, input int frd, input int lrd,
                            input int nmd, input int fmd, input int lmd, input int dn,
                            input int clr, input int ab);
        check_eq({nm, "_n_issue"},    st_nrd[u], nrd);
        check_eq({nm, "_first_issue"}, st_frd[u], frd);
        check_eq({nm, "_last_issue"}, st_lrd[u], lrd);
        check_eq({nm, "_n_mdone"},    st_nmd[u], nmd);
        check_eq({nm, "_first_mdone"}, st_fmd[u], fmd);
        check_eq({nm, "_last_mdone"}, st_lmd[u], lmd);
        check_eq({nm, "_done_cycle"}, st_done[u], dn);
        check_eq({nm, "_clr_cycle"},  st_clr[u], clr);
        check_eq({nm, "_aborted_end"}, st_ab[u], ab);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) model_reset(u);
        clear_stats();
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full pass with start during RUN (5) and DONE (11), stop after last issue (19) and in IDLE (27)
        scenario(30, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 11), (64'd1 << 19) | (64'd1 << 27), 64'd0);
        chk_pass("full_2x2x2", 0, 8, 1, 8, 8, 3, 10, 11, -1, 0);
        chk_pass("full_3x3x2", 1, 18, 1, 18, 18, 2, 19, 20, -1, 0);
        check_eq("full_3x3x2_last_tag_row", st_tr[1], 2);
        check_eq("full_3x3x2_last_tag_col", st_tc[1], 1);
        check_eq("full_3x3x2_last_tag_k",   st_tk[1], 2);

        // Abort in cycle 4
        scenario(14, 64'd1, 64'd1 << 4, 64'd0);
        chk_pass("abort_2x2x2", 0, 3, 1, 3, 3, 3, 5, 6, 6, 1);
        chk_pass("abort_3x3x2", 1, 3, 1, 3, 3, 2, 4, 6, 6, 1);

        // start+stop together in IDLE; stop again in cycle 9
        scenario(30, 64'd1, (64'd1 << 0) | (64'd1 << 9), 64'd0);
        chk_pass("ststop_2x2x2", 0, 8, 1, 8, 8, 3, 10, 11, -1, 0);
        chk_pass("ststop_3x3x2", 1, 8, 1, 8, 8, 2, 9, 11, 11, 1);

        // Reset in cycle 5 of a pass
        scenario(15, 64'd1, 64'd0, 64'd1 << 5);
        chk_pass("rst_2x2x2", 0, 4, 1, 4, 2, 3, 4, -1, -1, 0);
        chk_pass("rst_3x3x2", 1, 4, 1, 4, 3, 2, 4, -1, -1, 0);

        // Fresh pass after reset
        scenario(30, 64'd1, 64'd0, 64'd0);
        chk_pass("after_rst_2x2x2", 0, 8, 1, 8, 8, 3, 10, 11, -1, 0);
        chk_pass("after_rst_3x3x2", 1, 18, 1, 18, 18, 2, 19, 20, -1, 0);

        // Random start/stop/reset traffic judged by the model alone
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
